// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder.
//   - field widths and bit offsets of the 16-bit I-type instruction
//   - legal signed immediate range
//   - FSM state enumeration and captured-operand record
//   - helpers: range check and field packing
package imm_encoder_pkg;

    localparam int OPCODE_W = 4;
    localparam int RS_W     = 3;
    localparam int RT_W     = 3;
    localparam int IMM_W    = 6;
    localparam int VALUE_W  = 32;
    localparam int INSTR_W  = OPCODE_W + RS_W + RT_W + IMM_W;

    localparam int OPCODE_LSB = 12;
    localparam int RS_LSB     = 9;
    localparam int RT_LSB     = 6;
    localparam int IMM_LSB    = 0;

    localparam int IMM_MIN = -32;
    localparam int IMM_MAX = 31;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [RS_W-1:0]     rs;
        logic [RT_W-1:0]     rt;
        logic [VALUE_W-1:0]  value;
    } operand_t;

    // True when the 32-bit two's-complement value fits the 6-bit signed field.
    function automatic logic imm_in_range(input logic [VALUE_W-1:0] value);
        return ($signed(value) >= IMM_MIN) && ($signed(value) <= IMM_MAX);
    endfunction

    function automatic logic [INSTR_W-1:0] encode(
        input logic [OPCODE_W-1:0] opcode,
        input logic [RS_W-1:0]     rs,
        input logic [RT_W-1:0]     rt,
        input logic [IMM_W-1:0]    imm
    );
        logic [INSTR_W-1:0] instr;
        instr = '0;
        instr[OPCODE_LSB +: OPCODE_W] = opcode;
        instr[RS_LSB     +: RS_W]     = rs;
        instr[RT_LSB     +: RT_W]     = rt;
        instr[IMM_LSB    +: IMM_W]    = imm;
        return instr;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded instructions.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   push_i, wdata_i: write strobe and data (caller never pushes into a full
//                    FIFO unless it pops on the same edge)
//   pop_i          : read strobe, advances the head
//   rdata_o        : current head, zero while empty
//   count_o        : number of stored entries (0..DEPTH)
module instr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;

    // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop_i) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Memory is not reset; gating keeps the head at zero while empty.
    assign rdata_o = (count_q != '0) ? mem_q[rptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/imm_encoder.sv
// Encodes opcode/rs/rt plus a 32-bit signed immediate into a 16-bit I-type
// instruction, rejecting immediates that do not fit in 6 signed bits.
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   in_opcode, in_rs,
//   in_rt, in_value      : operand fields
//   out_valid / out_ready: instruction handshake from the output FIFO
//   out_instr            : FIFO head
//   err                  : one-cycle pulse per rejected operand
//   err_count            : saturating rejection count
//   instr_count          : wrapping count of popped instructions
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// CHECK | operand captured; push it, reject it, or stall on a full FIFO
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic [RS_W-1:0]     in_rs,
    input  logic [RT_W-1:0]     in_rt,
    input  logic [VALUE_W-1:0]  in_value,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic                err,
    output logic [7:0]          err_count,
    output logic [15:0]         instr_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    state_e            state_q;
    operand_t          op_q;
    logic              err_q;
    logic [7:0]        err_count_q;
    logic [15:0]       instr_count_q;

    logic [CNT_W-1:0]  fifo_count;
    logic [INSTR_W-1:0] fifo_head;
    logic              fifo_full;
    logic              legal;
    logic              push;
    logic              pop;

    always_comb begin
        fifo_full = (fifo_count == DEPTH_CNT);
        legal     = imm_in_range(op_q.value);
        pop       = (fifo_count != '0) && out_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push      = (state_q == CHECK) && legal && (!fifo_full || pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= '0;
            err_q         <= 1'b0;
            err_count_q   <= '0;
            instr_count_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (pop) begin
                instr_count_q <= instr_count_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q.opcode <= in_opcode;
                        op_q.rs     <= in_rs;
                        op_q.rt     <= in_rt;
                        op_q.value  <= in_value;
                        state_q     <= CHECK;
                    end
                end
                CHECK: begin
                    if (!legal) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end else if (push) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (encode(op_q.opcode, op_q.rs, op_q.rt, op_q.value[IMM_W-1:0])),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (fifo_count != '0);
    assign out_instr   = fifo_head;
    assign err         = err_q;
    assign err_count   = err_count_q;
    assign instr_count = instr_count_q;

endmodule
